// File: rtl/echo_delay_proc_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | echo_pkg: shared mode/state encodings and saturation helper for     |
// | echo_delay_proc.                          Revision: 1.0             |
// +---------------------------------------------------------------------+
package echo_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_FF     = 2'd1,
        MODE_FB     = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CALC = 2'd2,
        S_WR   = 2'd3
    } state_t;

    // Clamp a signed value to the two's-complement range of a w-bit word.
    function automatic logic signed [31:0] sat_dw(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            sat_dw = hi;
        end else if (v < lo) begin
            sat_dw = lo;
        end else begin
            sat_dw = v;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/echo_delay_proc_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | echo_delay_proc_if: sample strobe, controls and processed output.   |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
interface echo_delay_proc_if #(
    parameter int DW = 10,
    parameter int AW = 13
);
    logic          data_valid;
    logic [DW-1:0] data_in;
    logic [AW-1:0] delay;
    logic [1:0]    mode;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          busy;
    logic          overrun;
    logic [19:0]   bcd;

    modport master (
        output data_valid, data_in, delay, mode,
        input  data_out, out_valid, busy, overrun, bcd
    );

    modport slave (
        input  data_valid, data_in, delay, mode,
        output data_out, out_valid, busy, overrun, bcd
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | bin2bcd_seq: sequential double-dabble, one bit per cycle; bcd holds |
// | the finished result while done pulses.    Revision: 1.0            |
// +---------------------------------------------------------------------+
module bin2bcd_seq #(
    parameter int AW = 13
) (
    input  logic          sysclk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] bin,
    output logic [19:0]   bcd,
    output logic          done
);
    localparam int CW = $clog2(AW + 1);

    logic [AW-1:0] sh_q,   sh_d;
    logic [19:0]   work_q, work_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          run_q,  run_d;
    logic          done_q, done_d;
    logic [19:0]   adj;

    always_comb begin
        sh_d   = sh_q;
        work_d = work_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        adj    = work_q;
        if (start) begin
            sh_d   = bin;
            work_d = '0;
            cnt_d  = CW'(AW);
            run_d  = 1'b1;
        end else if (run_q) begin
            for (int i = 0; i < 5; i++) begin
                if (adj[4*i +: 4] >= 4'd5) begin
                    adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
                end
            end
            work_d = (adj << 1) | {19'b0, sh_q[AW-1]};
            sh_d   = sh_q << 1;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            work_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            work_q <= work_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign bcd  = work_q;
    assign done = done_q;
endmodule
`default_nettype wire

// File: rtl/echo_delay_proc.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | echo_delay_proc: circular-buffer echo (bypass/FF/FB) with shift     |
// | attenuation and saturation. Macro ECHO_BCD_DISPLAY_EN enables the   |
// | BCD delay readout.                        Revision: 1.0             |
// +---------------------------------------------------------------------+
module echo_delay_proc
    import echo_pkg::*;
#(
    parameter int DW          = 10,
    parameter int AW          = 13,
    parameter int ATTEN_SHIFT = 1
) (
    input  logic             sysclk,
    input  logic             rst_n,
    echo_delay_proc_if.slave bus
);
    localparam int            DEPTH    = 2 ** AW;
    localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};
    localparam logic [AW:0]   FILL_MAX = {1'b1, {AW{1'b0}}};

    state_t               state_q,    state_d;
    logic [AW-1:0]        wr_ptr_q,   wr_ptr_d;
    logic [AW:0]          fill_q,     fill_d;
    logic signed [DW:0]   x_s_q,      x_s_d;
    logic [AW-1:0]        d_lat_q,    d_lat_d;
    logic [1:0]           m_lat_q,    m_lat_d;
    logic signed [DW:0]   t_q,        t_d;
    logic [DW-1:0]        wr_data_q,  wr_data_d;
    logic [DW-1:0]        data_out_q, data_out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q,     busy_d;
    logic                 overrun_q,  overrun_d;

    logic [DW-1:0]        mem [DEPTH];
    logic [DW-1:0]        ram_dout;
    logic [AW-1:0]        ram_addr;
    logic                 ram_we;

    logic                 w_accept;
    logic                 w_echo_on;
    logic signed [DW:0]   w_q_s;
    logic signed [DW+1:0] w_y_s;
    logic [DW-1:0]        w_y_sat;
    logic [DW-1:0]        w_y_off;

    assign w_accept = bus.data_valid && (state_q == S_IDLE);

    // Single port: the write owns the address in WR, otherwise it points at
    // the tap so the read issued on the accepting edge lands during RD.
    assign ram_we   = (state_q == S_WR);
    assign ram_addr = ram_we ? wr_ptr_q : (wr_ptr_q - bus.delay);

    always_ff @(posedge sysclk) begin
        if (ram_we) begin
            mem[ram_addr] <= wr_data_q;
        end
        ram_dout <= mem[ram_addr];
    end

    assign w_q_s     = $signed({1'b0, ram_dout}) - $signed({1'b0, MIDSCALE});
    assign w_echo_on = (d_lat_q != '0) && (fill_q >= {1'b0, d_lat_q})
                       && ((m_lat_q == MODE_FF) || (m_lat_q == MODE_FB));
    assign w_y_s     = {x_s_q[DW], x_s_q} + {t_q[DW], t_q};
    assign w_y_sat   = DW'(sat_dw(32'(w_y_s), DW));
    assign w_y_off   = w_y_sat + MIDSCALE;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        x_s_d       = x_s_q;
        d_lat_d     = d_lat_q;
        m_lat_d     = m_lat_q;
        t_d         = t_q;
        wr_data_d   = wr_data_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        overrun_d   = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (bus.data_valid) begin
                    state_d = S_RD;
                    busy_d  = 1'b1;
                    x_s_d   = $signed({1'b0, bus.data_in}) - $signed({1'b0, MIDSCALE});
                    d_lat_d = bus.delay;
                    m_lat_d = bus.mode;
                end
            end
            S_RD: begin
                state_d = S_CALC;
                if (w_echo_on) begin
                    t_d = w_q_s >>> ATTEN_SHIFT;
                end else begin
                    t_d = '0;
                end
            end
            S_CALC: begin
                state_d     = S_WR;
                data_out_d  = w_y_off;
                out_valid_d = 1'b1;
                if (m_lat_q == MODE_FB) begin
                    wr_data_d = w_y_off;
                end else begin
                    wr_data_d = x_s_q[DW-1:0] + MIDSCALE;
                end
            end
            S_WR: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + (AW+1)'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.data_valid && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            x_s_q       <= '0;
            d_lat_q     <= '0;
            m_lat_q     <= '0;
            t_q         <= '0;
            wr_data_q   <= '0;
            data_out_q  <= MIDSCALE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            x_s_q       <= x_s_d;
            d_lat_q     <= d_lat_d;
            m_lat_q     <= m_lat_d;
            t_q         <= t_d;
            wr_data_q   <= wr_data_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

`ifdef ECHO_BCD_DISPLAY_EN
    logic [19:0] bcd_work;
    logic        bcd_done;
    logic [19:0] bcd_q, bcd_d;

    // The converter input is the same value being latched into d_lat.
    bin2bcd_seq #(.AW(AW)) u_bin2bcd (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .start  (w_accept),
        .bin    (bus.delay),
        .bcd    (bcd_work),
        .done   (bcd_done)
    );

    always_comb begin
        bcd_d = bcd_q;
        if (bcd_done) begin
            bcd_d = bcd_work;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bus.bcd = bcd_q;
`else
    assign bus.bcd = 20'h0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_echo_delay_proc.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_echo_delay_proc: directed bench for echo_delay_proc (AW=13 and   |
// | AW=4 instances).                          Revision: 1.0             |
// +---------------------------------------------------------------------+
module tb_echo_delay_proc;
    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    always #10 sysclk = ~sysclk;

    echo_delay_proc_if #(.DW(10), .AW(13)) bus ();
    echo_delay_proc_if #(.DW(10), .AW(4))  bus4 ();

    echo_delay_proc #(.DW(10), .AW(13), .ATTEN_SHIFT(1)) u_dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    echo_delay_proc #(.DW(10), .AW(4), .ATTEN_SHIFT(1)) u_dut4 (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (bus4)
    );

    task automatic do_reset();
        bus.data_valid  = 1'b0;
        bus4.data_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
    endtask

    // Strobe one sample, sample out_valid one cycle early and at the
    // expected latency, and return to an IDLE-aligned negedge.
    task automatic send(input logic [9:0] x, input logic [12:0] d, input logic [1:0] m,
                        output logic early, output logic ov, output logic [9:0] dout);
        bus.data_in = x; bus.delay = d; bus.mode = m; bus.data_valid = 1'b1;
        @(negedge sysclk);
        bus.data_valid = 1'b0;
        @(negedge sysclk);
        early = bus.out_valid;
        @(negedge sysclk);
        ov = bus.out_valid; dout = bus.data_out;
        @(negedge sysclk);
    endtask

    task automatic send4(input logic [9:0] x, input logic [3:0] d, input logic [1:0] m,
                         output logic ov, output logic [9:0] dout);
        bus4.data_in = x; bus4.delay = d; bus4.mode = m; bus4.data_valid = 1'b1;
        @(negedge sysclk);
        bus4.data_valid = 1'b0;
        @(negedge sysclk);
        @(negedge sysclk);
        ov = bus4.out_valid; dout = bus4.data_out;
        @(negedge sysclk);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.data_out !== 10'd512) begin bad++; $display("FAIL reset_data_out: got %0d expected 512", bus.data_out); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
        total++; if (bus.bcd !== 20'h0) begin bad++; $display("FAIL reset_bcd: got %h expected 00000", bus.bcd); end
        total++; if (bus4.data_out !== 10'd512) begin bad++; $display("FAIL reset_data_out4: got %0d expected 512", bus4.data_out); end
    endtask

    task automatic test_bypass();
        logic e, v; logic [9:0] o;
        do_reset();
        repeat (5000) @(negedge sysclk);
        total++; if (bus.data_out !== 10'd512) begin bad++; $display("FAIL bypass_idle: got %0d expected 512", bus.data_out); end
        for (int i = 0; i < 3; i++) begin
            send(10'd700, 13'd0, 2'd0, e, v, o);
            total++; if (e !== 1'b0) begin bad++; $display("FAIL bypass_early_valid: got %b expected 0", e); end
            total++; if (v !== 1'b1) begin bad++; $display("FAIL bypass_valid: got %b expected 1", v); end
            total++; if (o !== 10'd700) begin bad++; $display("FAIL bypass_out: got %0d expected 700", o); end
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bypass_pulse_width: got %b expected 0", bus.out_valid); end
            repeat (4996) @(negedge sysclk);
            total++; if (bus.data_out !== 10'd700) begin bad++; $display("FAIL bypass_hold: got %0d expected 700", bus.data_out); end
        end
        send(10'd700, 13'd2, 2'd3, e, v, o);
        total++; if (o !== 10'd700) begin bad++; $display("FAIL mode3_bypass: got %0d expected 700", o); end
        send(10'd300, 13'd0, 2'd1, e, v, o);
        total++; if (o !== 10'd300) begin bad++; $display("FAIL ff_delay0: got %0d expected 300", o); end
    endtask

    task automatic test_feedforward();
        int xin  [6] = '{768, 512, 512, 512, 512, 512};
        int xexp [6] = '{768, 512, 512, 512, 640, 512};
        logic e, v; logic [9:0] o;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(10'(xin[i]), 13'd4, 2'd1, e, v, o);
            total++;
            if (v !== 1'b1 || o !== 10'(xexp[i])) begin
                bad++; $display("FAIL ff_echo[%0d]: got %0d/valid %b expected %0d", i, o, v, xexp[i]);
            end
        end
    endtask

    task automatic test_feedback();
        int xexp [7] = '{768, 512, 640, 512, 576, 512, 544};
        logic e, v; logic [9:0] o;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send((i == 0) ? 10'd768 : 10'd512, 13'd2, 2'd2, e, v, o);
            total++;
            if (v !== 1'b1 || o !== 10'(xexp[i])) begin
                bad++; $display("FAIL fb_echo[%0d]: got %0d/valid %b expected %0d", i, o, v, xexp[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int xin  [5] = '{1000, 1000, 1000, 20, 20};
        int xexp [5] = '{1000, 1023, 1023, 264, 0};
        logic e, v; logic [9:0] o;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(10'(xin[i]), 13'd1, 2'd1, e, v, o);
            total++;
            if (o !== 10'(xexp[i])) begin
                bad++; $display("FAIL sat[%0d]: got %0d expected %0d", i, o, xexp[i]);
            end
        end
    endtask

    task automatic test_wrap_fill();
        logic v; logic [9:0] o;
        int exp_o;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            send4(10'(512 + 8 * k), 4'd15, 2'd1, v, o);
            exp_o = (k < 15) ? (512 + 8 * k) : (512 + 8 * k + 4 * (k - 15));
            total++;
            if (v !== 1'b1 || o !== 10'(exp_o)) begin
                bad++; $display("FAIL wrap[%0d]: got %0d/valid %b expected %0d", k, o, v, exp_o);
            end
        end
    endtask

    task automatic test_overrun();
        int pulses;
        do_reset();
        bus.delay = 13'd0; bus.mode = 2'd0;
        bus.data_in = 10'd600; bus.data_valid = 1'b1;
        @(negedge sysclk);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_set: got %b expected 1", bus.busy); end
        bus.data_in = 10'd900;
        @(negedge sysclk);
        bus.data_valid = 1'b0;
        @(negedge sysclk);
        total++; if (bus.out_valid !== 1'b1 || bus.data_out !== 10'd600) begin
            bad++; $display("FAIL overrun_first: got %0d/valid %b expected 600", bus.data_out, bus.out_valid); end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b expected 1", bus.overrun); end
        pulses = 0;
        repeat (10) begin @(negedge sysclk); if (bus.out_valid === 1'b1) pulses++; end
        total++; if (pulses != 0) begin bad++; $display("FAIL overrun_dropped: got %0d pulses expected 0", pulses); end
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got %b expected 1", bus.overrun); end

        do_reset();
        total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b expected 0", bus.overrun); end
        bus.data_in = 10'd600; bus.data_valid = 1'b1;
        @(negedge sysclk);
        bus.data_valid = 1'b0;
        repeat (2) @(negedge sysclk);
        bus.data_in = 10'd900; bus.data_valid = 1'b1;
        @(negedge sysclk);
        bus.data_valid = 1'b0;
        total++; if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_wr_cycle: got %b expected 1", bus.overrun); end
        pulses = 0;
        repeat (10) begin @(negedge sysclk); if (bus.out_valid === 1'b1) pulses++; end
        total++; if (pulses != 0 || bus.data_out !== 10'd600) begin
            bad++; $display("FAIL wr_cycle_dropped: got %0d pulses out %0d expected 0 pulses out 600", pulses, bus.data_out); end
    endtask

    task automatic test_async_reset();
        logic e, v; logic [9:0] o;
        do_reset();
        bus.delay = 13'd0; bus.mode = 2'd0;
        bus.data_in = 10'd700; bus.data_valid = 1'b1;
        @(negedge sysclk);
        bus.data_valid = 1'b0;
        @(negedge sysclk);
        #3 rst_n = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.data_out !== 10'd512) begin
            bad++; $display("FAIL async_reset: got busy %b valid %b out %0d expected 0 0 512", bus.busy, bus.out_valid, bus.data_out); end
        @(negedge sysclk);
        rst_n = 1'b1;
        @(negedge sysclk);
        send(10'd250, 13'd0, 2'd0, e, v, o);
        total++; if (v !== 1'b1 || o !== 10'd250) begin
            bad++; $display("FAIL after_async_reset: got %0d/valid %b expected 250", o, v); end
    endtask

    task automatic test_bcd();
        logic e, v; logic [9:0] o;
        logic [19:0] exp1, exp2;
`ifdef ECHO_BCD_DISPLAY_EN
        exp1 = 20'h04321; exp2 = 20'h08191;
`else
        exp1 = 20'h00000; exp2 = 20'h00000;
`endif
        do_reset();
        bus.data_in = 10'd512; bus.delay = 13'd4321; bus.mode = 2'd0; bus.data_valid = 1'b1;
        @(negedge sysclk);
        bus.data_valid = 1'b0;
        repeat (14) @(negedge sysclk);
        total++; if (bus.bcd !== exp1) begin bad++; $display("FAIL bcd_4321: got %h expected %h", bus.bcd, exp1); end
        send(10'd512, 13'd99, 2'd0, e, v, o);
        bus.data_in = 10'd512; bus.delay = 13'd8191; bus.data_valid = 1'b1;
        @(negedge sysclk);
        bus.data_valid = 1'b0;
        repeat (14) @(negedge sysclk);
        total++; if (bus.bcd !== exp2) begin bad++; $display("FAIL bcd_restart: got %h expected %h", bus.bcd, exp2); end
    endtask

    initial begin
        repeat (95000) @(posedge sysclk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.data_valid = 1'b0; bus.data_in = '0; bus.delay = '0; bus.mode = '0;
        bus4.data_valid = 1'b0; bus4.data_in = '0; bus4.delay = '0; bus4.mode = '0;
        test_reset();
        test_bypass();
        test_feedforward();
        test_feedback();
        test_saturation();
        test_wrap_fill();
        test_overrun();
        test_async_reset();
        test_bcd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
